// File: rtl/gpio_seq_pkg.sv
// Shared constants for the GPIO pattern sequencer: register map, CTRL/STATUS
// bit positions and FSM state encoding.
package gpio_seq_pkg;
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_DATA   = 5'h08;
  localparam logic [4:0] OFF_PRESC  = 5'h0C;
  localparam logic [4:0] OFF_MASK   = 5'h10;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_LOOP = 1;
  localparam int CTRL_CLR  = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
endpackage

// File: rtl/gpio_seq_if.sv
// Peripheral bus bundle shared by the GPIO block and the pattern sequencer.
interface gpio_seq_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/gpio_seq_fifo.sv
// Entry FIFO with flush and a peek pointer that can walk the stored entries
// (wrapping oldest<-newest) without consuming them, used for looped playback.
module gpio_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 23,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic          start_i,
  input  logic          adv_i,
  input  logic          loop_i,
  output logic [W-1:0]  head_o,
  output logic [W-1:0]  next_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, pk_q, last, nxt_idx;
  logic [LW-1:0] cnt_q;
  logic          push_ok;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign last    = wr_q - 1'b1;
  assign nxt_idx = loop_i ? ((pk_q == last) ? rd_q : pk_q + 1'b1) : rd_q + 1'b1;
  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[nxt_idx];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      pk_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_i) begin
        rd_q <= rd_q + 1'b1;
        pk_q <= rd_q + 1'b1;
      end else if (adv_i) begin
        pk_q <= nxt_idx;
      end else if (start_i) begin
        pk_q <= rd_q;
      end
      cnt_q <= cnt_q + LW'(push_ok) - LW'(pop_i);
    end
  end
endmodule

// File: rtl/gpio_seq.sv
// Timed GPIO pattern sequencer: plays queued (pattern, hold) entries on masked pins.
// Build option GPIO_SEQ_PRESC_EN adds the PRESC register and tick prescaler.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter logic [31:0] SEQ_BASE_ADDR = 32'h40002000,
  parameter int NUM_PINS   = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  gpio_seq_if.slave           bus,
  input  logic [NUM_PINS-1:0] gpio_cpu_out,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic                seq_done
);
  localparam int EW = HOLD_W + NUM_PINS;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                hit, wr_ctrl, wr_status, wr_mask, push, clr;
  logic [4:0]          off;
  logic                en_q, loop_q, ovf_q, done_q, done_d;
  logic [NUM_PINS-1:0] mask_q, pat_q, pat_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          state_q, state_d;
  logic                pop, adv, start, tick, run_act;
  logic [EW-1:0]       head, nxt;
  logic [LW-1:0]       level;
  logic                full, empty;
  logic [31:0]         rd_val;
  logic                unused_ok;

  function automatic logic [HOLD_W-1:0] hold1(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  assign hit       = (bus.mem_addr[31:8] == SEQ_BASE_ADDR[31:8]);
  assign off       = bus.mem_addr[4:0];
  assign wr_ctrl   = bus.mem_we && hit && (off == OFF_CTRL);
  assign wr_status = bus.mem_we && hit && (off == OFF_STATUS);
  assign wr_mask   = bus.mem_we && hit && (off == OFF_MASK);
  assign push      = bus.mem_we && hit && (off == OFF_DATA);
  assign clr       = wr_ctrl && bus.mem_wdata[CTRL_CLR];
  assign unused_ok = ^{bus.mem_addr, bus.mem_wdata};

  gpio_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(push), .data_i({bus.mem_wdata[16 +: HOLD_W], bus.mem_wdata[NUM_PINS-1:0]}),
    .pop_i(pop), .flush_i(clr), .start_i(start), .adv_i(adv), .loop_i(loop_q),
    .head_o(head), .next_o(nxt), .level_o(level), .full_o(full), .empty_o(empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      loop_q <= 1'b0;
      mask_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q   <= bus.mem_wdata[CTRL_EN];
        loop_q <= bus.mem_wdata[CTRL_LOOP];
      end
      if (wr_mask) mask_q <= bus.mem_wdata[NUM_PINS-1:0];
      if (push && full && !pop && !clr) ovf_q <= 1'b1;
      else if (wr_status && bus.mem_wdata[ST_OVF]) ovf_q <= 1'b0;
    end
  end

`ifdef GPIO_SEQ_PRESC_EN
  logic [15:0] presc_q, psc_q, plat_q;
  logic        prestart;
  assign tick     = (psc_q == plat_q);
  assign prestart = start;

  // The divisor is latched per tick period so a PRESC write never cuts one short.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      psc_q   <= '0;
      plat_q  <= '0;
    end else begin
      if (bus.mem_we && hit && (off == OFF_PRESC)) presc_q <= bus.mem_wdata[15:0];
      if (prestart || (run_act && tick)) begin
        psc_q  <= '0;
        plat_q <= presc_q;
      end else if (run_act) begin
        psc_q <= psc_q + 16'd1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    adv     = 1'b0;
    start   = 1'b0;
    run_act = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!clr && en_q && !empty) begin
          state_d = S_RUN;
          start   = 1'b1;
          pat_d   = head[NUM_PINS-1:0];
          cnt_d   = hold1(head[EW-1 -: HOLD_W]);
        end
      end
      S_RUN, S_PAUSE: begin
        if (clr) begin
          state_d = S_IDLE;
        end else if (!en_q) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_RUN;
          run_act = 1'b1;
          if (tick && cnt_q == HOLD_W'(1)) begin
            if (loop_q) adv = 1'b1;
            else        pop = 1'b1;
            if (loop_q || level > LW'(1)) begin
              pat_d = nxt[NUM_PINS-1:0];
              cnt_d = hold1(nxt[EW-1 -: HOLD_W]);
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else if (tick) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL: begin
        rd_val[CTRL_EN]   = en_q;
        rd_val[CTRL_LOOP] = loop_q;
      end
      OFF_STATUS: begin
        rd_val[ST_LVL +: LW] = level;
        rd_val[ST_OVF]       = ovf_q;
        rd_val[ST_FULL]      = full;
        rd_val[ST_EMPTY]     = empty;
        rd_val[ST_BUSY]      = (state_q != S_IDLE);
      end
`ifdef GPIO_SEQ_PRESC_EN
      OFF_PRESC: rd_val[15:0] = presc_q;
`endif
      OFF_MASK: rd_val[NUM_PINS-1:0] = mask_q;
      default: rd_val = '0;
    endcase
  end

  assign bus.mem_rdata = (hit && bus.mem_re) ? rd_val : '0;
  assign gpio_out = (state_q != S_IDLE) ? ((mask_q & pat_q) | (~mask_q & gpio_cpu_out))
                                        : gpio_cpu_out;
  assign seq_done = done_q;
endmodule

// File: tb/tb_gpio_seq.sv
// Directed bench for gpio_seq: one task per scenario, hand-computed expectations.
module tb_gpio_seq;
  localparam logic [31:0] BASE = 32'h40002000;

  logic       clk, rst_n;
  logic [6:0] gpio_cpu_out, gpio_out;
  logic       seq_done;
  int         checks, errors;

  gpio_seq_if bus();

  gpio_seq dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .gpio_cpu_out(gpio_cpu_out), .gpio_out(gpio_out), .seq_done(seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_wr(input logic [4:0] off, input logic [31:0] d);
    bus.mem_addr  = BASE | {27'd0, off};
    bus.mem_wdata = d;
    bus.mem_we    = 1'b1;
    @(posedge clk); #1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d);
    bus.mem_addr = addr;
    bus.mem_re   = 1'b1;
    #1 d = bus.mem_rdata;
    bus.mem_re   = 1'b0;
    bus.mem_addr = '0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    gpio_cpu_out = 7'h2A;
    do_reset();
    bus_rd(BASE + 32'h00, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", r, 32'h0); end
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", r, 32'h2); end
    bus_rd(BASE + 32'h10, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp %h", r, 32'h0); end
    bus_rd(BASE + 32'h0C, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_presc got %h exp %h", r, 32'h0); end
    checks++; if (gpio_out !== 7'h2A) begin errors++; $display("FAIL reset_gpio got %h exp %h", gpio_out, 7'h2A); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", seq_done); end
    bus_wr(5'h10, 32'hFFFF_FFFF);
    bus_rd(BASE + 32'h10, r);
    checks++; if (r !== 32'h7F) begin errors++; $display("FAIL mask_rw got %h exp %h", r, 32'h7F); end
    bus.mem_we = 1'b0;
    bus_rd(BASE + 32'h14, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h exp %h", r, 32'h0); end
    bus_rd(32'h40003010, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL miss_rd got %h exp %h", r, 32'h0); end
  endtask

  task automatic test_basic_seq();
    logic [6:0]  exp_g [6];
    logic        exp_d [6];
    logic [31:0] r;
    int          dn;
    exp_g = '{7'h55, 7'h55, 7'h2A, 7'h2A, 7'h11, 7'h11};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    gpio_cpu_out = 7'h11;
    do_reset();
    bus_wr(5'h10, 32'h7F);
    bus_wr(5'h0C, 32'h0);
    bus_wr(5'h00, 32'h1);
    bus_wr(5'h08, {16'd3, 16'h55});
    bus_wr(5'h08, {16'd2, 16'h2A});
    dn = int'(seq_done);
    checks++; if (gpio_out !== 7'h55) begin errors++; $display("FAIL seq_first got %h exp %h", gpio_out, 7'h55); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      dn += int'(seq_done);
      checks++; if (gpio_out !== exp_g[i]) begin errors++; $display("FAIL seq_cyc%0d got %h exp %h", i, gpio_out, exp_g[i]); end
      checks++; if (seq_done !== exp_d[i]) begin errors++; $display("FAIL seq_done%0d got %b exp %b", i, seq_done, exp_d[i]); end
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL seq_done_count got %0d exp 1", dn); end
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL seq_status_end got %h exp %h", r, 32'h2); end
  endtask

  task automatic test_presc();
    logic [31:0] r;
    int hi, dn, exp_hi;
    logic [31:0] exp_p;
`ifdef GPIO_SEQ_PRESC_EN
    exp_hi = 4; exp_p = 32'h3;
`else
    exp_hi = 1; exp_p = 32'h0;
`endif
    gpio_cpu_out = 7'h00;
    do_reset();
    bus_wr(5'h10, 32'h7F);
    bus_wr(5'h0C, 32'h0001_0003);
    bus_rd(BASE + 32'h0C, r);
    checks++; if (r !== exp_p) begin errors++; $display("FAIL presc_rd got %h exp %h", r, exp_p); end
    bus_wr(5'h00, 32'h1);
    bus_wr(5'h08, {16'd0, 16'h01});
    hi = 0; dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      hi += int'(gpio_out[0]);
      dn += int'(seq_done);
    end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL presc_hold_cycles got %0d exp %0d", hi, exp_hi); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL presc_done got %0d exp 1", dn); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 8; i++) bus_wr(5'h08, {16'd1, 16'(i)});
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h804) begin errors++; $display("FAIL ovf_full got %h exp %h", r, 32'h804); end
    bus_wr(5'h08, {16'd1, 16'h7F});
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h80C) begin errors++; $display("FAIL ovf_set got %h exp %h", r, 32'h80C); end
    bus_rd(BASE + 32'h08, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL data_rd got %h exp %h", r, 32'h0); end
    bus_wr(5'h04, 32'h8);
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h804) begin errors++; $display("FAIL ovf_w1c got %h exp %h", r, 32'h804); end
  endtask

  task automatic test_loop();
    logic [31:0] r;
    logic [6:0]  e;
    int dn;
    gpio_cpu_out = 7'h00;
    do_reset();
    bus_wr(5'h10, 32'h7F);
    bus_wr(5'h08, {16'd1, 16'h0A});
    bus_wr(5'h08, {16'd1, 16'h0B});
    bus_wr(5'h00, 32'h3);
    checks++; if (gpio_out !== 7'h00) begin errors++; $display("FAIL loop_idle got %h exp %h", gpio_out, 7'h00); end
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e = (i % 2 == 0) ? 7'h0A : 7'h0B;
      dn += int'(seq_done);
      checks++; if (gpio_out !== e) begin errors++; $display("FAIL loop_cyc%0d got %h exp %h", i, gpio_out, e); end
    end
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h201) begin errors++; $display("FAIL loop_status got %h exp %h", r, 32'h201); end
    bus_wr(5'h00, 32'h4);
    dn += int'(seq_done);
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL clr_status got %h exp %h", r, 32'h2); end
    checks++; if (gpio_out !== 7'h00) begin errors++; $display("FAIL clr_gpio got %h exp %h", gpio_out, 7'h00); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dn += int'(seq_done);
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL loop_no_done got %0d exp 0", dn); end
  endtask

  task automatic test_mask();
    logic [31:0] r;
    gpio_cpu_out = 7'h7C;
    do_reset();
    bus_wr(5'h10, 32'h03);
    bus_wr(5'h00, 32'h1);
    bus_wr(5'h08, {16'd2, 16'h7F});
    bus_wr(5'h08, {16'd2, 16'h00});
    checks++; if (gpio_out !== 7'h7F) begin errors++; $display("FAIL mask_pat7f got %h exp %h", gpio_out, 7'h7F); end
    @(posedge clk); #1;
    checks++; if (gpio_out !== 7'h7F) begin errors++; $display("FAIL mask_pat7f_2 got %h exp %h", gpio_out, 7'h7F); end
    @(posedge clk); #1;
    checks++; if (gpio_out !== 7'h7C) begin errors++; $display("FAIL mask_pat00 got %h exp %h", gpio_out, 7'h7C); end
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h101) begin errors++; $display("FAIL mask_status got %h exp %h", r, 32'h101); end
  endtask

  task automatic test_pause_reset();
    logic [31:0] r;
    gpio_cpu_out = 7'h00;
    do_reset();
    bus_wr(5'h10, 32'h7F);
    bus_wr(5'h00, 32'h1);
    bus_wr(5'h08, {16'd5, 16'h33});
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_wr(5'h00, 32'h0);
    checks++; if (gpio_out !== 7'h33) begin errors++; $display("FAIL pause_enter got %h exp %h", gpio_out, 7'h33); end
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      checks++; if (gpio_out !== 7'h33 || seq_done !== 1'b0) begin errors++; $display("FAIL pause_frozen%0d got %h exp %h", i, gpio_out, 7'h33); end
    end
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h101) begin errors++; $display("FAIL pause_status got %h exp %h", r, 32'h101); end
    bus_wr(5'h00, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (gpio_out !== 7'h33) begin errors++; $display("FAIL resume_last got %h exp %h", gpio_out, 7'h33); end
    @(posedge clk); #1;
    checks++; if (gpio_out !== 7'h00) begin errors++; $display("FAIL resume_end got %h exp %h", gpio_out, 7'h00); end
    checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL resume_done got %b exp 1", seq_done); end
    // reset while an entry is playing
    gpio_cpu_out = 7'h15;
    bus_wr(5'h08, {16'd10, 16'h33});
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (gpio_out !== 7'h33) begin errors++; $display("FAIL rst_pre got %h exp %h", gpio_out, 7'h33); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (gpio_out !== 7'h15) begin errors++; $display("FAIL rst_gpio got %h exp %h", gpio_out, 7'h15); end
    bus_rd(BASE + 32'h04, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL rst_status got %h exp %h", r, 32'h2); end
    bus_rd(BASE + 32'h00, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp %h", r, 32'h0); end
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    gpio_cpu_out = '0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_we = 1'b0; bus.mem_re = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic_seq();
    test_presc();
    test_overflow();
    test_loop();
    test_mask();
    test_pause_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
